// File: rtl/seg_scan_driver_if.sv
// ============================================================================
// Module : seg_scan_driver_if
// Brief  : Segment-word, brightness and display-pin bundle for seg_scan_driver.
//          The blink_mask member exists only when SEG_BLINK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg_scan_driver_if;
  logic [55:0] seg_in;
  logic [2:0]  brightness;
  logic [6:0]  seg_pins;
  logic [7:0]  dig_en;
  logic        frame_start;
`ifdef SEG_BLINK_EN
  logic [7:0]  blink_mask;

  modport master (
    output seg_in, brightness, blink_mask,
    input  seg_pins, dig_en, frame_start
  );

  modport slave (
    input  seg_in, brightness, blink_mask,
    output seg_pins, dig_en, frame_start
  );
`else
  modport master (
    output seg_in, brightness,
    input  seg_pins, dig_en, frame_start
  );

  modport slave (
    input  seg_in, brightness,
    output seg_pins, dig_en, frame_start
  );
`endif
endinterface

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module : seg_scan_driver
// Brief  : 8-digit common-anode 7-segment scan driver with per-slot blanking,
//          8-step brightness PWM and once-per-frame word latching.
//          Optional digit blinking is enabled by defining SEG_BLINK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int c_cnt_w     = $clog2(DIGIT_CYCLES);
  localparam int c_thr_w     = c_cnt_w + 4;
  localparam int c_on_cycles = DIGIT_CYCLES - BLANK_CYCLES;
  localparam int c_step      = c_on_cycles / 8;

  if ((DIGIT_CYCLES < BLANK_CYCLES + 8) || (BLANK_CYCLES < 1) || (BLINK_FRAMES < 1))
  begin : g_param_check
    $error("seg_scan_driver: illegal DIGIT_CYCLES/BLANK_CYCLES/BLINK_FRAMES");
  end

  logic [c_cnt_w-1:0] r_slot_cnt;
  logic [2:0]         r_digit;
  logic [55:0]        r_frame;
  logic [2:0]         r_bri;
  logic [6:0]         r_seg;
  logic [7:0]         r_dig;
  logic               r_frame_start;

  logic               w_slot_end;
  logic               w_frame_edge;
  logic [c_thr_w-1:0] w_cnt_ext;
  logic [c_thr_w-1:0] w_lit_end;
  logic               w_lit;
  logic               w_dark;
  logic [6:0]         w_digits [8];
  logic [6:0]         w_digit_seg;
  logic [7:0]         w_dig_onehot;

  // Slot k shows the k-th 7-bit field counted from the MSB end.
  for (genvar k = 0; k < 8; k++) begin : g_unpack
    assign w_digits[k] = r_frame[55-7*k -: 7];
  end

  assign w_slot_end   = (r_slot_cnt == c_cnt_w'(DIGIT_CYCLES - 1));
  assign w_frame_edge = (r_slot_cnt == '0) && (r_digit == 3'd0);
  assign w_cnt_ext    = c_thr_w'(r_slot_cnt);
  assign w_lit_end    = c_thr_w'(BLANK_CYCLES)
                      + (c_thr_w'(r_bri) + c_thr_w'(1)) * c_thr_w'(c_step);
  assign w_lit        = (w_cnt_ext >= c_thr_w'(BLANK_CYCLES)) && (w_cnt_ext < w_lit_end);
  assign w_digit_seg  = w_digits[r_digit];
  assign w_dig_onehot = ~(8'h80 >> r_digit);

`ifdef SEG_BLINK_EN
  localparam int c_fc_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [c_fc_w-1:0] r_frame_cnt;
  logic              r_blink_phase;
  logic [7:0]        r_mask;
  logic              w_frame_end;

  assign w_frame_end = w_slot_end && (r_digit == 3'd7);
  // Slot k drives dig_en[7-k], so the mask is indexed from the top.
  assign w_dark      = r_blink_phase && r_mask[3'd7 - r_digit];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_mask        <= 8'h00;
    end else begin
      if (w_frame_edge) begin
        r_mask <= bus.blink_mask;
      end
      if (w_frame_end) begin
        if (r_frame_cnt == c_fc_w'(BLINK_FRAMES - 1)) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + c_fc_w'(1);
        end
      end
    end
  end
`else
  assign w_dark = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt    <= '0;
      r_digit       <= 3'd0;
      r_frame       <= '1;
      r_bri         <= 3'd0;
      r_seg         <= 7'h7F;
      r_dig         <= 8'hFF;
      r_frame_start <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_slot_cnt <= '0;
        r_digit    <= r_digit + 3'd1;
      end else begin
        r_slot_cnt <= r_slot_cnt + c_cnt_w'(1);
      end

      if (r_slot_cnt == '0) begin
        r_bri <= bus.brightness;
      end

      if (w_frame_edge) begin
        r_frame <= bus.seg_in;
      end
      r_frame_start <= w_frame_edge;

      // Slot start is always blanked, so the stale word/brightness seen on
      // the latching edge itself never reaches the pins.
      if (w_lit && !w_dark) begin
        r_seg <= w_digit_seg;
        r_dig <= w_dig_onehot;
      end else begin
        r_seg <= 7'h7F;
        r_dig <= 8'hFF;
      end
    end
  end

  assign bus.seg_pins    = r_seg;
  assign bus.dig_en      = r_dig;
  assign bus.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module : tb_seg_scan_driver
// Brief  : Directed self-checking bench for seg_scan_driver (20-cycle slots,
//          4 blank cycles, 2-frame blink); blink test runs with SEG_BLINK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

  localparam logic [55:0] WORD_A = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [55:0] WORD_B = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  bit   clk_run = 1'b0;
  logic rst_n;

  int n_vec  = 0;
  int n_fail = 0;

  logic [6:0] cap_seg [160];
  logic [7:0] cap_dig [160];

  seg_scan_driver_if u_if();

  seg_scan_driver #(
    .DIGIT_CYCLES(20),
    .BLANK_CYCLES(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  always #5 if (clk_run) clk = ~clk;

  // Expected {seg_pins, dig_en} for frame position i (slot i/20, count i%20).
  function automatic logic [14:0] exp_out(input logic [55:0] w, input int i,
                                          input int b, input bit dark);
    int d, c;
    logic [7:0] sel;
    d   = i / 20;
    c   = i % 20;
    sel = 8'h80 >> d;
    if (!dark && c >= 4 && c < 4 + (b + 1) * 2) return {w[55-7*d -: 7], ~sel};
    return {7'h7F, 8'hFF};
  endfunction

  // Waits for frame_start, then records 160 samples; sample 0 is the pulse.
  task automatic capture(output bit ok, input int bri_idx, input logic [2:0] bri_new,
                         input int seg_idx, input logic [55:0] seg_new);
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (u_if.frame_start === 1'b1) ok = 1'b1;
    end
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      cap_seg[i] = u_if.seg_pins;
      cap_dig[i] = u_if.dig_en;
      if (i == bri_idx) u_if.brightness = bri_new;
      if (i == seg_idx) u_if.seg_in = seg_new;
    end
  endtask

  task automatic test_reset();
    bit found;
    int first_k;
    u_if.seg_in     = WORD_A;
    u_if.brightness = 3'd7;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (u_if.seg_pins !== 7'h7F) begin
      n_fail++; $display("FAIL reset_seg: got %h want 7f", u_if.seg_pins);
    end
    n_vec++;
    if (u_if.dig_en !== 8'hFF) begin
      n_fail++; $display("FAIL reset_dig: got %h want ff", u_if.dig_en);
    end
    n_vec++;
    if (u_if.frame_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_fs: got %b want 0", u_if.frame_start);
    end
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      if (u_if.frame_start === 1'b1) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_fail++; $display("FAIL first_fs: got no pulse want pulse within 4 cycles");
    end
    first_k = 0;
    for (int k = 1; k <= 170 && first_k == 0; k++) begin
      @(negedge clk);
      if (u_if.frame_start === 1'b1) first_k = k;
    end
    n_vec++;
    if (first_k != 160) begin
      n_fail++; $display("FAIL fs_period: got %0d want 160", first_k);
    end
  endtask

  task automatic test_scan_order();
    bit ok;
    capture(ok, -1, 3'd0, -1, '0);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL scan_fs: got timeout want pulse"); end
    for (int i = 0; i < 160; i++) begin
      logic [14:0] e;
      e = exp_out(WORD_A, i, 7, 1'b0);
      n_vec++;
      if ({cap_seg[i], cap_dig[i]} !== e) begin
        n_fail++;
        $display("FAIL scan i=%0d: got %h/%h want %h/%h", i, cap_seg[i], cap_dig[i], e[14:8], e[7:0]);
      end
    end
  endtask

  task automatic test_brightness();
    bit ok;
    int b;
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 0) u_if.brightness = 3'd0;
      if (pass == 1) u_if.brightness = 3'd3;
      if (pass == 2) capture(ok, 50, 3'd7, -1, '0);
      else           capture(ok, -1, 3'd0, -1, '0);
      n_vec++;
      if (!ok) begin n_fail++; $display("FAIL bri_fs pass=%0d: got timeout want pulse", pass); end
      for (int i = 0; i < 160; i++) begin
        logic [14:0] e;
        if (pass == 0)      b = 0;
        else if (pass == 1) b = 3;
        else                b = ((i / 20) * 20 > 50) ? 7 : 3;
        e = exp_out(WORD_A, i, b, 1'b0);
        n_vec++;
        if ({cap_seg[i], cap_dig[i]} !== e) begin
          n_fail++;
          $display("FAIL bri pass=%0d i=%0d: got %h/%h want %h/%h", pass, i,
                   cap_seg[i], cap_dig[i], e[14:8], e[7:0]);
        end
      end
    end
  endtask

  task automatic test_anti_tear();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) capture(ok, -1, 3'd0, 65, WORD_B);
      else           capture(ok, -1, 3'd0, -1, '0);
      n_vec++;
      if (!ok) begin n_fail++; $display("FAIL tear_fs pass=%0d: got timeout want pulse", pass); end
      for (int i = 0; i < 160; i++) begin
        logic [14:0] e;
        e = exp_out((pass == 0) ? WORD_A : WORD_B, i, 7, 1'b0);
        n_vec++;
        if ({cap_seg[i], cap_dig[i]} !== e) begin
          n_fail++;
          $display("FAIL tear pass=%0d i=%0d: got %h/%h want %h/%h", pass, i,
                   cap_seg[i], cap_dig[i], e[14:8], e[7:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (u_if.frame_start === 1'b1) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_fail++; $display("FAIL mid_fs: got timeout want pulse"); end
    repeat (112) @(negedge clk);
    n_vec++;
    if ({u_if.seg_pins, u_if.dig_en} !== {7'h21, 8'hFB}) begin
      n_fail++; $display("FAIL mid_pre: got %h/%h want 21/fb", u_if.seg_pins, u_if.dig_en);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({u_if.seg_pins, u_if.dig_en, u_if.frame_start} !== {7'h7F, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_idle: got %h/%h/%b want 7f/ff/0", u_if.seg_pins, u_if.dig_en, u_if.frame_start);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (u_if.frame_start !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart_fs: got %b want 1", u_if.frame_start);
    end
    for (int s = 1; s <= 4; s++) begin
      logic [14:0] e;
      @(negedge clk);
      e = (s < 4) ? {7'h7F, 8'hFF} : {7'h00, 8'h7F};
      n_vec++;
      if ({u_if.seg_pins, u_if.dig_en} !== e) begin
        n_fail++;
        $display("FAIL mid_restart s=%0d: got %h/%h want %h/%h", s, u_if.seg_pins, u_if.dig_en, e[14:8], e[7:0]);
      end
    end
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    bit ok;
    bit dark;
    @(negedge clk);
    rst_n = 1'b0;
    u_if.blink_mask = 8'h03;
    u_if.seg_in     = WORD_A;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 8; f++) begin
      capture(ok, -1, 3'd0, -1, '0);
      n_vec++;
      if (!ok) begin n_fail++; $display("FAIL blink_fs f=%0d: got timeout want pulse", f); end
      for (int i = 0; i < 160; i++) begin
        logic [14:0] e;
        dark = (((f / 2) % 2) == 1) && (i / 20 >= 6);
        e = exp_out(WORD_A, i, 7, dark);
        n_vec++;
        if ({cap_seg[i], cap_dig[i]} !== e) begin
          n_fail++;
          $display("FAIL blink f=%0d i=%0d: got %h/%h want %h/%h", f, i,
                   cap_seg[i], cap_dig[i], e[14:8], e[7:0]);
        end
      end
    end
  endtask
`endif

  initial begin
`ifdef SEG_BLINK_EN
    u_if.blink_mask = 8'h00;
`endif
    test_reset();
    test_scan_order();
    test_brightness();
    test_anti_tear();
    test_reset_mid_slot();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
